// File: rtl/cache_pkg.sv
// Shared types and default geometry for the 2-way cache tag controller.
// Tag RAM word layout is {valid, tag}.
package cache_pkg;

    localparam int DEF_AWIDTH = 3;
    localparam int DEF_DWIDTH = 14;
    localparam int TWIDTH     = DEF_DWIDTH - 1;
    localparam int VALID_BIT  = DEF_DWIDTH - 1;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_REFILL = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way choice: first invalid way, otherwise the set's LRU bit.
// The LRU bit names the way to evict next.
module cache_victim_sel (
    input  logic valid0,
    input  logic valid1,
    input  logic lru,
    output logic victim
);

    always_comb begin
        victim = 1'b0;
        priority case (1'b1)
            !valid0: victim = 1'b0;
            !valid1: victim = 1'b1;
            default: victim = lru;
        endcase
    end

endmodule

// File: rtl/cache_tag_ctrl.sv
// Lookup/allocate controller for a 2-way set-associative cache with
// synchronous-read tag RAMs, per-set LRU bits and a refill handshake.
module cache_tag_ctrl
    import cache_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req_valid,
    input  logic [DWIDTH+AWIDTH-2:0]  req_addr,
    output logic                      req_ready,
    output logic                      rsp_valid,
    output logic                      rsp_hit,
    output logic                      rsp_way,
    output logic [AWIDTH-1:0]         tr_addr,
    output logic [DWIDTH-1:0]         tr_din,
    output logic                      tr_we0,
    output logic                      tr_we1,
    input  logic [DWIDTH-1:0]         tr_dout0,
    input  logic [DWIDTH-1:0]         tr_dout1,
    output logic                      mem_req,
    output logic [DWIDTH+AWIDTH-2:0]  mem_addr,
    input  logic                      mem_ack
);

    localparam int TW    = DWIDTH - 1;
    localparam int VB    = DWIDTH - 1;
    localparam int DEPTH = 1 << AWIDTH;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic [AWIDTH-1:0]   idx_q, idx_d;
    logic [TW-1:0]       tag_q, tag_d;
    logic                victim_q, victim_d;
    logic [DEPTH-1:0]    lru_q, lru_d;

    logic hit0, hit1, hit_any, hit_way, vic_sel;

    assign hit0    = tr_dout0[VB] && (tr_dout0[TW-1:0] == tag_q);
    assign hit1    = tr_dout1[VB] && (tr_dout1[TW-1:0] == tag_q);
    assign hit_any = hit0 | hit1;
    // Both ways matching is illegal; way 0 takes precedence.
    assign hit_way = ~hit0;

    cache_victim_sel u_victim_sel (
        .valid0 (tr_dout0[VB]),
        .valid1 (tr_dout1[VB]),
        .lru    (lru_q[idx_q]),
        .victim (vic_sel)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            idx_q    <= '0;
            tag_q    <= '0;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tag_q    <= tag_d;
            victim_q <= victim_d;
            lru_q    <= lru_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        tag_d    = tag_q;
        victim_d = victim_q;
        lru_d    = lru_q;
        unique case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                lru_d = '0;
                if (cnt_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid) begin
                    tag_d   = req_addr[AWIDTH +: TW];
                    idx_d   = req_addr[AWIDTH-1:0];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    lru_d[idx_q] = ~hit_way;
                    state_d      = S_IDLE;
                end else begin
                    victim_d = vic_sel;
                    state_d  = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_ack) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                lru_d[idx_q] = ~victim_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign mem_addr = {tag_q, idx_q};

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_hit   = 1'b0;
        rsp_way   = 1'b0;
        tr_addr   = idx_q;
        tr_din    = '0;
        tr_we0    = 1'b0;
        tr_we1    = 1'b0;
        mem_req   = 1'b0;
        unique case (state_q)
            S_INIT: begin
                tr_addr = cnt_q;
                tr_we0  = 1'b1;
                tr_we1  = 1'b1;
            end
            S_IDLE: begin
                req_ready = 1'b1;
                tr_addr   = req_addr[AWIDTH-1:0];
            end
            S_LOOKUP: begin
                rsp_valid = hit_any;
                rsp_hit   = hit_any;
                rsp_way   = hit_way;
            end
            S_REFILL: begin
                mem_req = 1'b1;
            end
            S_UPDATE: begin
                tr_din    = {1'b1, tag_q};
                tr_we0    = ~victim_q;
                tr_we1    = victim_q;
                rsp_valid = 1'b1;
                rsp_way   = victim_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed bench for cache_tag_ctrl with behavioural sync-read tag RAMs.
// Vector table drives lookups; hand sequences cover reset and stray acks.
module tb_cache_tag_ctrl;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_hit;
    logic        rsp_way;
    logic [2:0]  tr_addr;
    logic [13:0] tr_din;
    logic        tr_we0;
    logic        tr_we1;
    logic [13:0] tr_dout0;
    logic [13:0] tr_dout1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;

    int total;
    int passed;

    cache_tag_ctrl dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_hit  (rsp_hit),
        .rsp_way  (rsp_way),
        .tr_addr  (tr_addr),
        .tr_din   (tr_din),
        .tr_we0   (tr_we0),
        .tr_we1   (tr_we1),
        .tr_dout0 (tr_dout0),
        .tr_dout1 (tr_dout1),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Tag RAMs start full of valid entries so the INIT sweep is observable.
    logic [13:0] ram0 [8];
    logic [13:0] ram1 [8];
    logic        seeded = 1'b0;

    always @(posedge clock) begin
        if (!seeded) begin
            for (int i = 0; i < 8; i++) begin
                ram0[i] <= 14'h2005;
                ram1[i] <= 14'h2006;
            end
            seeded <= 1'b1;
        end else begin
            if (tr_we0) ram0[tr_addr] <= tr_din;
            if (tr_we1) ram1[tr_addr] <= tr_din;
        end
        tr_dout0 <= ram0[tr_addr];
        tr_dout1 <= ram1[tr_addr];
    end

    typedef struct {
        logic [12:0] tag;
        logic [2:0]  idx;
        int          dly;
        logic        hit;
        logic        way;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_tr_addr", int'(tr_addr), 0);
        chk("rst_tr_din", int'(tr_din), 0);
        chk("rst_tr_we0", int'(tr_we0), 1);
        chk("rst_tr_we1", int'(tr_we1), 1);
    endtask

    // Entered on the negedge where reset_n is released.
    task automatic check_init();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clock);
            chk("init_we0", int'(tr_we0), 1);
            chk("init_we1", int'(tr_we1), 1);
            chk("init_addr", int'(tr_addr), i);
            chk("init_din", int'(tr_din), 0);
            chk("init_ready_low", int'(req_ready), 0);
        end
        @(negedge clock);
        chk("init_done_ready", int'(req_ready), 1);
        chk("init_done_we0", int'(tr_we0), 0);
    endtask

    task automatic access(input logic [12:0] tag, input logic [2:0] idx,
                          input int dly, input logic ehit,
                          input logic eway);
        @(negedge clock);
        chk("idle_ready", int'(req_ready), 1);
        req_addr  = {tag, idx};
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("lookup_ready_low", int'(req_ready), 0);
        chk("lookup_rsp_valid", int'(rsp_valid), int'(ehit));
        if (ehit) begin
            chk("hit_rsp_hit", int'(rsp_hit), 1);
            chk("hit_rsp_way", int'(rsp_way), int'(eway));
            chk("hit_no_mem_req", int'(mem_req), 0);
        end else begin
            chk("lookup_no_we", int'(tr_we0 | tr_we1), 0);
            @(negedge clock);
            chk("refill_mem_req", int'(mem_req), 1);
            chk("refill_mem_addr", int'(mem_addr), int'({tag, idx}));
            chk("refill_rsp_low", int'(rsp_valid), 0);
            for (int k = 1; k < dly; k++) begin
                @(negedge clock);
                chk("refill_wait_req", int'(mem_req), 1);
                chk("refill_wait_rsp", int'(rsp_valid), 0);
            end
            mem_ack = 1'b1;
            @(negedge clock);
            mem_ack = 1'b0;
            chk("upd_rsp_valid", int'(rsp_valid), 1);
            chk("upd_rsp_hit", int'(rsp_hit), 0);
            chk("upd_rsp_way", int'(rsp_way), int'(eway));
            chk("upd_we0", int'(tr_we0), int'(!eway));
            chk("upd_we1", int'(tr_we1), int'(eway));
            chk("upd_din", int'(tr_din), int'({1'b1, tag}));
            chk("upd_addr", int'(tr_addr), int'(idx));
            chk("upd_mem_req_low", int'(mem_req), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        passed = 0;
        vecs[0]  = '{13'h0005, 3'd2, 3, 1'b0, 1'b0};
        vecs[1]  = '{13'h0005, 3'd2, 0, 1'b1, 1'b0};
        vecs[2]  = '{13'h0006, 3'd2, 1, 1'b0, 1'b1};
        vecs[3]  = '{13'h0007, 3'd2, 2, 1'b0, 1'b0};
        vecs[4]  = '{13'h0006, 3'd2, 0, 1'b1, 1'b1};
        vecs[5]  = '{13'h0005, 3'd2, 1, 1'b0, 1'b0};
        vecs[6]  = '{13'h0007, 3'd2, 1, 1'b0, 1'b1};
        vecs[7]  = '{13'h1FFF, 3'd7, 1, 1'b0, 1'b0};
        vecs[8]  = '{13'h1FFF, 3'd7, 0, 1'b1, 1'b0};
        vecs[9]  = '{13'h0000, 3'd0, 2, 1'b0, 1'b0};
        vecs[10] = '{13'h0000, 3'd0, 0, 1'b1, 1'b0};
        vecs[11] = '{13'h1FFE, 3'd7, 1, 1'b0, 1'b1};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        mem_ack   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_reset_outputs();
        reset_n = 1'b1;
        check_init();

        for (int v = 0; v < 12; v++)
            access(vecs[v].tag, vecs[v].idx, vecs[v].dly,
                   vecs[v].hit, vecs[v].way);

        // Stray ack while idle must not disturb anything.
        @(negedge clock);
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        chk("stray_ack_rsp", int'(rsp_valid), 0);
        chk("stray_ack_ready", int'(req_ready), 1);
        chk("stray_ack_mem_req", int'(mem_req), 0);
        chk("stray_ack_we", int'(tr_we0 | tr_we1), 0);
        access(13'h0005, 3'd2, 0, 1'b1, 1'b0);

        // Reset while a refill is outstanding.
        @(negedge clock);
        req_addr  = {13'h00AA, 3'd2};
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        chk("pre_rst_mem_req", int'(mem_req), 1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clock);
        reset_n = 1'b1;
        check_init();
        access(13'h0005, 3'd2, 1, 1'b0, 1'b0);
        access(13'h0005, 3'd2, 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_tag_ctrl.md
# cache_tag_ctrl

Lookup and allocation controller for a 2-way set-associative cache built from two synchronous-read tag RAMs (way 0, way 1). It sequences the shared tag RAM address and per-way write enables, compares tags, and keeps one LRU bit per set. On a miss it runs a refill handshake with the next memory level, then allocates a victim way. It sits between the CPU request port and the tag RAMs and memory interface in the cache top level.

## Interface
- AWIDTH, 3: set index width; DEPTH = 2^AWIDTH sets.
- DWIDTH, 14: tag RAM word width; word = {valid, tag}, TWIDTH = DWIDTH-1.
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  CPU lookup request.
- req_addr  in  TWIDTH+AWIDTH  block address {tag, index}.
- req_ready  out  1  controller accepts request this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_hit  out  1  1 = hit, 0 = miss-then-allocated.
- rsp_way  out  1  way hit or allocated.
- tr_addr  out  AWIDTH  shared tag RAM address.
- tr_din  out  DWIDTH  tag RAM write data (both ways).
- tr_we0, tr_we1  out  1  per-way write enables.
- tr_dout0, tr_dout1  in  DWIDTH  tag RAM read data; valid the cycle after tr_addr is sampled.
- mem_req  out  1  refill request, held until acknowledged.
- mem_addr  out  TWIDTH+AWIDTH  refill block address.
- mem_ack  in  1  refill complete.

## Operation
- States: INIT, IDLE, LOOKUP, REFILL, UPDATE.
- INIT: counter 0..DEPTH-1; tr_addr = counter, tr_din = 0, tr_we0 = tr_we1 = 1; all LRU bits 0. After counter = DEPTH-1, go to IDLE. req_ready = 0.
- IDLE: req_ready = 1. tr_addr = req_addr index (combinational). On req_valid, register tag/index, go to LOOKUP.
- LOOKUP: tr_addr = registered index. hitN = tr_doutN[DWIDTH-1] and tr_doutN tag equals registered tag. Both match (illegal): way 0 wins. Hit: rsp_valid = 1, rsp_hit = 1, rsp_way = hit way, lru[index] <= ~hit way, go to IDLE. Miss: latch victim, go to REFILL.
- Victim: way 0 if invalid, else way 1 if invalid, else lru[index] (lru bit = way to evict next).
- REFILL: mem_req = 1, mem_addr = registered {tag, index}. On mem_ack, go to UPDATE. mem_ack outside REFILL is ignored.
- UPDATE: tr_addr = index, tr_din = {1, tag}, tr_we of victim = 1. rsp_valid = 1, rsp_hit = 0, rsp_way = victim. lru[index] <= ~victim. Go to IDLE.
- tr_we0/tr_we1 are 0 in every state except INIT and UPDATE.

## Timing
- Reset (reset_n low, asynchronous): state = INIT, counter = 0, LRU = 0. Outputs: req_ready = 0, rsp_valid = 0, mem_req = 0, tr_addr = 0, tr_din = 0, tr_we0 = tr_we1 = 1.
- Reset mid-operation aborts any refill: mem_req drops immediately, and the INIT sweep reinvalidates all tags.
- After reset release: DEPTH cycles of INIT. req_ready rises in cycle DEPTH.
- Hit: request accepted at edge E. rsp_valid is high in the cycle after E. The next accept is possible no earlier than edge E+2.
- Miss: LOOKUP occupies cycle E+1, and mem_req rises in cycle E+2. If mem_ack arrives in the first REFILL cycle, UPDATE and rsp_valid occur in cycle E+3. Each extra wait cycle adds one cycle of latency.
- The tag write in UPDATE commits at the end of the UPDATE cycle. A back-to-back request to the same set reads the new tag.

## Structure
- Shared package cache_pkg: state encoding, VALID_BIT = DWIDTH-1, TWIDTH = DWIDTH-1, default AWIDTH/DWIDTH.
- One sub-module, cache_victim_sel: combinational; inputs are the two valid bits and the LRU bit; outputs the victim way.
- The LRU bit array (DEPTH flops) lives in cache_tag_ctrl. The tag RAMs are instantiated by the cache top, not here.

## Test plan
- Reset, release: tr_we0/tr_we1 high for 8 cycles at addresses 0..7 with din 0; req_ready rises on cycle 8.
- Cold miss to req_addr {tag 0x05, index 2}, mem_ack after 3 cycles: mem_addr = {0x05, 2}; UPDATE writes way 0 with din = 14'b1_0000000000101; rsp_hit = 0, rsp_way = 0.
- Repeat the same address: rsp_valid on the cycle after accept with rsp_hit = 1, rsp_way = 0, and no mem_req.
- Tags 0x05, 0x06, then 0x07 in set 2 (0x06 fills way 1, 0x07 evicts way 0). Next, access 0x06 (hit way 1), then 0x05: the miss evicts way 0, which holds tag 0x07.
- reset_n pulse low while mem_req is high: mem_req drops asynchronously, INIT reruns, and a subsequent access to 0x05 misses.
- mem_ack pulsed in IDLE: ignored; no state change, no rsp_valid.
